// File: rtl/sm_adder_tree_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : sm_adder_tree_acc_if
//  Description : Beat input / window result bundle for sm_adder_tree_acc.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sm_adder_tree_acc_if #(
    parameter int WIDTH  = 9,
    parameter int NUM_IN = 9,
    parameter int ACC_W  = 24
);
    logic                          in_valid;
    logic                          in_last;
    logic [NUM_IN*2*WIDTH-1:0]     in_data;
    logic                          out_valid;
    logic [ACC_W-1:0]              out_data;
    logic                          out_sat;

    modport master (
        output in_valid, in_last, in_data,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_last, in_data,
        output out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/sm_adder_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module      : sm_adder_tree_acc
//  Description : Registered sign-magnitude adder tree with saturating
//                per-window accumulator (one output channel).
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_adder_tree_acc #(
    parameter int WIDTH  = 9,
    parameter int NUM_IN = 9,
    parameter int ACC_W  = 24
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sm_adder_tree_acc_if.slave  bus
);

    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = $clog2(NUM_IN);
    localparam int TW     = PW + LEVELS;
    localparam int NP     = 1 << LEVELS;
    localparam int AW     = ACC_W + 1;
    localparam logic signed [AW-1:0] MAXV = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = -MAXV;

    if (NUM_IN < 2) begin : g_bad_num_in
        $error("sm_adder_tree_acc: NUM_IN must be 2 or more");
    end
    if (ACC_W - 1 < PW - 1 + LEVELS) begin : g_bad_acc_w
        $error("sm_adder_tree_acc: ACC_W too narrow for tree growth");
    end

    // Index 0 is the input register; index k (k>=1) is tree level k output.
    logic                    r_first_pend;
    logic [LEVELS:0]         r_vld;
    logic [LEVELS:0]         r_lst;
    logic [LEVELS:0]         r_fst;
    logic [NUM_IN*PW-1:0]    r_in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_pend <= 1'b1;
            r_vld        <= '0;
        end else begin
            r_vld <= {r_vld[LEVELS-1:0], bus.in_valid};
            if (bus.in_valid) begin
                r_first_pend <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_lst     <= {r_lst[LEVELS-1:0], bus.in_last};
        r_fst     <= {r_fst[LEVELS-1:0], r_first_pend};
        r_in_data <= bus.in_data;
    end

    logic signed [TW-1:0] w_lvl [LEVELS+1][NP];

    for (genvar i = 0; i < NP; i++) begin : g_lane
        if (i < NUM_IN) begin : g_conv
            logic          w_sign;
            logic [TW-1:0] w_mag;
            assign w_sign       = r_in_data[i*PW + PW-1];
            assign w_mag        = {{(LEVELS+1){1'b0}}, r_in_data[i*PW +: PW-1]};
            // -0 negates to 0, so it needs no special case.
            assign w_lvl[0][i]  = w_sign ? -$signed(w_mag) : $signed(w_mag);
        end else begin : g_zero
            assign w_lvl[0][i]  = '0;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NODES = NP >> (l + 1);
        for (genvar j = 0; j < NP; j++) begin : g_node
            if (j < NODES) begin : g_add
                logic signed [TW-1:0] r_node;
                always_ff @(posedge clk) begin
                    r_node <= w_lvl[l][2*j] + w_lvl[l][2*j+1];
                end
                assign w_lvl[l+1][j] = r_node;
            end else begin : g_pad
                assign w_lvl[l+1][j] = '0;
            end
        end
    end

    logic signed [AW-1:0]    r_acc;
    logic                    r_sat;
    logic                    r_out_valid;
    logic [ACC_W-1:0]        r_out_data;
    logic                    r_out_sat;

    logic signed [AW-1:0]    w_tree_ext;
    logic signed [AW-1:0]    w_sum;
    logic signed [AW-1:0]    w_acc_next;
    logic                    w_hi;
    logic                    w_lo;
    logic                    w_sat_next;
    logic                    w_neg;
    logic [ACC_W-2:0]        w_mag_out;

    assign w_tree_ext = {{(AW-TW){w_lvl[LEVELS][0][TW-1]}}, w_lvl[LEVELS][0]};

    always_comb begin
        w_sum      = (r_fst[LEVELS] ? '0 : r_acc) + w_tree_ext;
        w_hi       = (w_sum > MAXV);
        w_lo       = (w_sum < MINV);
        w_acc_next = w_sum;
        if (w_hi) begin
            w_acc_next = MAXV;
        end else if (w_lo) begin
            w_acc_next = MINV;
        end
        w_sat_next = (r_fst[LEVELS] ? 1'b0 : r_sat) | w_hi | w_lo;
        // Strict less-than keeps a zero result positive.
        w_neg      = (w_acc_next < 0);
        w_mag_out  = (ACC_W-1)'(w_neg ? -w_acc_next : w_acc_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= r_vld[LEVELS] & r_lst[LEVELS];
            if (r_vld[LEVELS]) begin
                r_acc <= w_acc_next;
                r_sat <= w_sat_next;
                if (r_lst[LEVELS]) begin
                    r_out_data <= {w_neg, w_mag_out};
                    r_out_sat  <= w_sat_next;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_sm_adder_tree_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_adder_tree_acc
//  Description : Scoreboard bench for sm_adder_tree_acc at default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_adder_tree_acc;

    localparam int WIDTH  = 9;
    localparam int NUM_IN = 9;
    localparam int ACC_W  = 24;
    localparam int PW     = 2 * WIDTH;
    localparam int DW     = NUM_IN * PW;
    localparam int LAT    = 5;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sm_adder_tree_acc_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .ACC_W(ACC_W)) bus ();

    sm_adder_tree_acc #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             sat;
        int               cyc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     pulses = 0;
    longint m_acc  = 0;
    bit     m_sat  = 1'b0;
    bit     m_first = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] sm(input longint v);
        logic [PW-1:0] r;
        r[PW-1]   = (v < 0);
        r[PW-2:0] = (PW-1)'(v < 0 ? -v : v);
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input longint v);
        logic [DW-1:0] d;
        for (int i = 0; i < NUM_IN; i++) d[i*PW +: PW] = sm(v);
        return d;
    endfunction

    function automatic logic [DW-1:0] lane0(input longint v);
        logic [DW-1:0] d;
        d          = '0;
        d[PW-1:0]  = sm(v);
        return d;
    endfunction

    // Reference model: decode lanes, accumulate, clamp, queue window result.
    task automatic model_beat(input logic [DW-1:0] d, input bit last, input int edge_cyc);
        longint t;
        logic [PW-1:0] ln;
        exp_t e;
        t = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            ln = d[i*PW +: PW];
            t  = ln[PW-1] ? t - longint'(ln[PW-2:0]) : t + longint'(ln[PW-2:0]);
        end
        if (m_first) begin
            m_acc = t;
            m_sat = 1'b0;
        end else begin
            m_acc = m_acc + t;
        end
        if (m_acc > MAXV) begin
            m_acc = MAXV;
            m_sat = 1'b1;
        end else if (m_acc < -MAXV) begin
            m_acc = -MAXV;
            m_sat = 1'b1;
        end
        m_first = last;
        if (last) begin
            e.data = {(m_acc < 0), (ACC_W-1)'(m_acc < 0 ? -m_acc : m_acc)};
            e.sat  = m_sat;
            e.cyc  = edge_cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_data  = d;
        model_beat(d, last, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            bus.in_data  = '0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        idle(1);
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            pulses = pulses + 1;
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_pulse: got out_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e  = sb.pop_front();
                checks = checks + 3;
                if (bus.out_data !== mon_e.data) begin
                    errors = errors + 1;
                    $display("FAIL pulse_data: got %h, required %h", bus.out_data, mon_e.data);
                end
                if (bus.out_sat !== mon_e.sat) begin
                    errors = errors + 1;
                    $display("FAIL pulse_sat: got %b, required %b", bus.out_sat, mon_e.sat);
                end
                if (cyc != mon_e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL pulse_latency: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks = checks + 3;
        if (bus.out_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_valid: got %b, required 0", bus.out_valid);
        end
        if (bus.out_data !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_data: got %h, required 0", bus.out_data);
        end
        if (bus.out_sat !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_sat: got %b, required 0", bus.out_sat);
        end
        m_first = 1'b1;
        sb.delete();
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_window(input string name, input int p0, input int exp_pulses,
                               input logic [ACC_W-1:0] exp_data, input logic exp_sat);
        checks = checks + 4;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_pending: got %0d outstanding windows, required 0", name, sb.size());
            sb.delete();
        end
        if (pulses - p0 != exp_pulses) begin
            errors = errors + 1;
            $display("FAIL %s_pulses: got %0d, required %0d", name, pulses - p0, exp_pulses);
        end
        if (bus.out_data !== exp_data) begin
            errors = errors + 1;
            $display("FAIL %s_data: got %h, required %h", name, bus.out_data, exp_data);
        end
        if (bus.out_sat !== exp_sat) begin
            errors = errors + 1;
            $display("FAIL %s_sat: got %b, required %b", name, bus.out_sat, exp_sat);
        end
    endtask

    task automatic test_single();
        int p0 = pulses;
        beat(fill(5), 1'b1);
        wait_drain();
        test_window("single", p0, 1, 24'h00002D, 1'b0);
    endtask

    task automatic test_mixed();
        int p0 = pulses;
        logic [DW-1:0] d;
        d = '0;
        d[0*PW +: PW] = sm(100);
        d[1*PW +: PW] = sm(-30);
        d[2*PW +: PW] = 18'h20000;
        d[3*PW +: PW] = sm(0);
        d[4*PW +: PW] = sm(-70);
        beat(d, 1'b1);
        wait_drain();
        test_window("mixed", p0, 1, 24'h000000, 1'b0);
    endtask

    task automatic test_multi_beat();
        int p0 = pulses;
        beat(lane0(1000), 1'b0);
        beat(lane0(-2500), 1'b0);
        idle(1);
        beat(lane0(700), 1'b1);
        wait_drain();
        test_window("multi", p0, 1, {1'b1, 23'd800}, 1'b0);
    endtask

    task automatic test_saturation();
        int p0 = pulses;
        for (int i = 0; i < 8; i++) beat(fill(131071), i == 7);
        wait_drain();
        test_window("sat", p0, 1, {1'b0, 23'd8388607}, 1'b1);
        p0 = pulses;
        beat(lane0(1), 1'b1);
        wait_drain();
        test_window("after_sat", p0, 1, 24'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        beat(lane0(9), 1'b1);
        beat(lane0(-18), 1'b1);
        wait_drain();
        test_window("b2b", p0, 2, {1'b1, 23'd18}, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        int p0 = pulses;
        beat(lane0(10), 1'b0);
        beat(lane0(10), 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst          = 1'b1;
        m_first      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        beat(lane0(3), 1'b1);
        wait_drain();
        test_window("rst_mid", p0, 1, 24'd3, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single();
        test_mixed();
        test_multi_beat();
        test_saturation();
        test_back_to_back();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sm_adder_tree_acc.md
Name: sm_adder_tree_acc

Overview:
- Pipelined, parametrised successor to the single two-operand sign-magnitude adder in the conv path.
- Each valid beat, sums NUM_IN sign-magnitude products through a registered adder tree.
- Accumulates tree sums across beats until a window-last marker, then emits one saturated sign-magnitude result per window.
- Sits between the multiplier array and the activation/pooling stage; one instance covers one output channel.

Parameters:
- WIDTH, 9: operand base width; each product is 2*WIDTH bits sign-magnitude (bit 2*WIDTH-1 = sign).
- NUM_IN, 9: products per beat (kernel taps per beat); legal range is 2 or more.
- ACC_W, 24: result width, sign-magnitude. Must satisfy ACC_W-1 >= 2*WIDTH-1+LEVELS, checked at elaboration.
- LEVELS (localparam), clog2(NUM_IN): number of tree stages; 4 at defaults.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat qualifier
- in_last  input  1  marks the final beat of a window; ignored when in_valid=0
- in_data  input  NUM_IN*2*WIDTH  packed products; lane i occupies [(i+1)*2*WIDTH-1 : i*2*WIDTH]
- out_valid  output  1  one-cycle pulse per completed window
- out_data  output  ACC_W  window sum, sign-magnitude
- out_sat  output  1  at least one clamp occurred in this window; qualified by out_valid

Behaviour:
- Reset: clears all pipeline valids, accumulator and window state. Outputs reset to out_valid=0, out_data=0, out_sat=0.
- Reset mid-window discards the partial sum and all in-flight beats. No out_valid follows from beats sampled before reset deasserts.
- Stage 0 (combinational at input): each lane is converted to two's complement at width 2*WIDTH+LEVELS. Magnitude with sign=1 is negated. -0 (sign=1, mag=0) is treated as 0.
- Tree: LEVELS registered stages of pairwise adds. An odd lane passes through with zero padding. No overflow is possible inside the tree.
- in_valid and in_last travel alongside the data as a valid/last sideband.
- First-beat flag: set after reset and after any beat carrying last. It travels with the beat.
- Accumulator stage: signed, ACC_W+1 bits internally.
  - First beat of a window: acc = tree_sum, sticky sat cleared.
  - Subsequent beats: acc = acc + tree_sum.
- Clamp after every add to ±(2^(ACC_W-1)-1). Any clamp sets sticky sat. Accumulation continues from the clamped value.
- Output register: updated in the same cycle as the accumulator write of a last beat.
  - out_valid=1 for exactly one cycle.
  - out_data = {sign, |acc|}.
  - A zero result always has sign 0 (no -0 output).
  - out_sat = sticky sat, including any clamp on the last beat.
- out_data and out_sat hold their value until the next window completes. out_valid is 0 otherwise.
- Latency: beat sampled with in_valid=1 and in_last=1 at edge t gives out_valid high after edge t+LEVELS+1 (5 cycles at defaults).
- Throughput: one beat per cycle with no bubbles. Back-to-back windows are supported.
  - A single-beat window (first and last together) is legal.
  - A window's last beat may be followed immediately by the next window's first beat.
- No backpressure: the consumer must accept every out_valid pulse.
- in_valid=0 cycles inside a window are permitted and leave the accumulator unchanged.

Test Plan:
- Single beat, all 9 lanes +5, in_last=1 → exactly 5 cycles later: out_valid pulse, out_data=+45 (0x00002D), out_sat=0.
- Mixed signs in one beat: lanes +100, -30, -0, +0, -70, and 0 elsewhere; last=1 → out_data=0 with sign bit 0 (zero, never -0), out_sat=0.
- 3-beat window, lane sums +1000, -2500, +700, with an idle cycle between beats 2 and 3 → one pulse, out_data = sign 1, magnitude 800; no pulse on non-last beats.
- Saturation: 8 beats, all lanes +131071 (tree sum 1179639 per beat) → out_data = sign 0, magnitude 8388607, out_sat=1. The next window of one beat at +1 gives out_data=+1, out_sat=0.
- Back-to-back: window A is a single beat at +9, window B is a single beat at -18, on consecutive cycles → pulses on consecutive cycles, +9 then sign 1 magnitude 18.
- Reset mid-window: two beats of +10, assert rst for 1 cycle, then one last beat of +3 → no pulse from the pre-reset beats; single pulse with out_data=+3.
